// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERR = 2'd2
  } arb_state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer width that never collapses to zero bits.
  function automatic int ptr_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after prio, circularly.
module rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] prio,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk the request vector starting at prio and keep the first hit.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(prio) + i) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one slave port shared by N_MASTER masters,
// grant held until the owner drops cyc, watchdog terminates stalled beats.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTER       = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rstn_i,
  input  logic [N_MASTER-1:0]          m_cyc_i,
  input  logic [N_MASTER-1:0]          m_stb_i,
  input  logic [N_MASTER-1:0]          m_we_i,
  input  logic [N_MASTER*ADDR_W-1:0]   m_adr_i,
  input  logic [N_MASTER*DATA_W-1:0]   m_dat_i,
  input  logic [N_MASTER*DATA_W/8-1:0] m_sel_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic [N_MASTER-1:0]          m_ack_o,
  output logic [N_MASTER-1:0]          m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  input  logic [DATA_W-1:0]            s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [N_MASTER-1:0]          grant_o,
  output logic                         timeout_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = ptr_w(N_MASTER);
  localparam int WD_W  = ptr_w(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     prio_q, prio_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [N_MASTER-1:0]  pick;
  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  logic [N_MASTER-1:0]  owner_oh;
  logic                 owner_cyc;
  logic                 owner_stb;

  // Priority pointer advances to the master after the one just served.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_MASTER - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  rr_picker #(
    .N     (N_MASTER),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (m_cyc_i),
    .prio  (prio_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Convert the one-hot pick into an owner index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  assign owner_oh  = N_MASTER'(1) << owner_q;
  assign owner_cyc = m_cyc_i[owner_q];
  assign owner_stb = m_stb_i[owner_q];
  assign m_dat_o   = s_dat_i;

  // State, priority pointer, owner and watchdog registers.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      owner_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic, slave-side mux and owner-only response routing.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    wd_d      = wd_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    grant_o   = '0;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant_o = owner_oh;
        s_cyc_o = owner_cyc;
        s_stb_o = owner_stb;
        s_we_o  = m_we_i[owner_q];
        s_adr_o = m_adr_i[int'(owner_q)*ADDR_W +: ADDR_W];
        s_dat_o = m_dat_i[int'(owner_q)*DATA_W +: DATA_W];
        s_sel_o = m_sel_i[int'(owner_q)*SEL_W +: SEL_W];
        m_ack_o = s_ack_i ? owner_oh : '0;
        m_err_o = s_err_i ? owner_oh : '0;
        if (!owner_cyc) begin
          // Release: slave already sees cyc low through the mux this cycle.
          state_d = IDLE;
          prio_d  = wrap_inc(owner_q);
          wd_d    = '0;
        end else if (!owner_stb || s_ack_i || s_err_i) begin
          // A termination in the expiry cycle wins over the watchdog.
          wd_d = '0;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
          state_d = TERR;
          wd_d    = '0;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      TERR: begin
        // Slave is cut off; the owner gets a synthetic error this cycle.
        grant_o   = owner_oh;
        m_err_o   = owner_oh;
        timeout_o = 1'b1;
        prio_d    = wrap_inc(owner_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a cycle-level reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // One cycle of stimulus plus optional hand-computed expectations.
  typedef struct {
    logic        rstn;
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic        ack;
    logic        err;
    logic [31:0] adr;
    logic        lit;
    logic [2:0]  g;
    logic [2:0]  a;
    logic [2:0]  e;
    logic        sc;
    logic        to;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  logic cur_vld = 1'b0;
  int   vidx = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: who owns the bus, who is next in line,
  // how many consecutive stalled beats, and whether a timeout is being reported.
  bit md_busy = 1'b0;
  bit md_terr = 1'b0;
  int md_owner = 0;
  int md_next = 0;
  int md_stalls = 0;

  task automatic add(input int r, input int c, input int s, input int ak, input int er,
                     input int ad, input int l, input int g, input int a, input int e,
                     input int sc, input int to);
    vec_t v;
    v.rstn = 1'(r); v.cyc = 3'(c); v.stb = 3'(s); v.ack = 1'(ak); v.err = 1'(er);
    v.adr = 32'(ad); v.lit = 1'(l); v.g = 3'(g); v.a = 3'(a); v.e = 3'(e);
    v.sc = 1'(sc); v.to = 1'(to);
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at vector %0d: got %0h, required %0h", nm, vidx, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input int i);
    return 3'(1 << i);
  endfunction

  // First requester at or after 'from', walking circularly.
  function automatic int rr_first(input logic [2:0] req, input int from);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (from + i) % N;
      if (req[j[1:0]]) return j;
    end
    return 0;
  endfunction

  // Reference model advances on each clock edge; reset clears it at once.
  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      md_busy <= 1'b0; md_terr <= 1'b0; md_owner <= 0; md_next <= 0; md_stalls <= 0;
    end else if (md_terr) begin
      md_terr <= 1'b0;
      md_next <= (md_owner + 1) % N;
    end else if (md_busy) begin
      if (!m_cyc_i[md_owner[1:0]]) begin
        md_busy <= 1'b0; md_next <= (md_owner + 1) % N; md_stalls <= 0;
      end else if (m_stb_i[md_owner[1:0]] && !s_ack_i && !s_err_i) begin
        if (TO != 0 && md_stalls + 1 == TO) begin
          md_busy <= 1'b0; md_terr <= 1'b1; md_stalls <= 0;
        end else begin
          md_stalls <= md_stalls + 1;
        end
      end else begin
        md_stalls <= 0;
      end
    end else if (m_cyc_i != 3'b000) begin
      md_busy <= 1'b1;
      md_owner <= rr_first(m_cyc_i, md_next);
      md_stalls <= 0;
    end
  end

  // Compare every output against the model, plus the literal pins of the vector.
  always @(negedge clk) begin
    if (cur_vld) begin
      chk("grant", 32'(grant_o), 32'((md_busy || md_terr) ? onehot(md_owner) : 3'b000));
      chk("s_cyc", 32'(s_cyc_o), 32'(md_busy && cur.cyc[md_owner[1:0]]));
      chk("s_stb", 32'(s_stb_o), 32'(md_busy && cur.stb[md_owner[1:0]]));
      chk("s_we", 32'(s_we_o), 32'(md_busy && cur.stb[md_owner[1:0]] && md_owner != 1));
      chk("s_adr", s_adr_o, md_busy ? cur.adr : 32'h0);
      chk("s_dat", s_dat_o, md_busy ? 32'hA5A5_0000 + 32'(md_owner) : 32'h0);
      chk("s_sel", 32'(s_sel_o), 32'(md_busy ? 4'(1 << md_owner) : 4'h0));
      chk("m_ack", 32'(m_ack_o), 32'((md_busy && cur.ack) ? onehot(md_owner) : 3'b000));
      chk("m_err", 32'(m_err_o),
          32'(((md_busy && cur.err) || md_terr) ? onehot(md_owner) : 3'b000));
      chk("timeout", 32'(timeout_o), 32'(md_terr));
      chk("m_dat", m_dat_o, 32'h5A00_0000 + 32'(vidx));
      if (cur.lit) begin
        chk("lit_grant", 32'(grant_o), 32'(cur.g));
        chk("lit_ack", 32'(m_ack_o), 32'(cur.a));
        chk("lit_err", 32'(m_err_o), 32'(cur.e));
        chk("lit_s_cyc", 32'(s_cyc_o), 32'(cur.sc));
        chk("lit_timeout", 32'(timeout_o), 32'(cur.to));
      end
    end
  end

  initial begin
    int oh;
    // Reset and idle.
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Single request from master 1, ack two cycles after the request.
    add(1, 'b010, 'b010, 0, 0, 'h4000, 1, 'b000, 'b000, 0, 0, 0);
    add(1, 'b010, 'b010, 0, 0, 'h4000, 1, 'b010, 'b000, 0, 1, 0);
    add(1, 'b010, 'b010, 1, 0, 'h4000, 1, 'b010, 'b010, 0, 1, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b010, 'b000, 0, 0, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b000, 'b000, 0, 0, 0);
    // Fresh reset, then all masters request continuously: 0,1,2,0,1,2.
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      oh = 1 << (k % 3);
      add(1, 'b111, 'b111, 0, 0, k * 16, 1, 0, 0, 0, 0, 0);
      add(1, 'b111, 'b111, 1, 0, k * 16, 1, oh, oh, 0, 1, 0);
      add(1, 'b111 & ~oh, 'b111 & ~oh, 0, 0, k * 16, 1, oh, 0, 0, 0, 0);
    end
    // Grant lock: master 2 bursts 4 beats while master 0 waits.
    add(1, 'b100, 'b100, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++)
      add(1, 'b101, 'b101, 1, 0, 'h100 * b, 1, 'b100, 'b100, 0, 1, 0);
    add(1, 'b001, 'b001, 0, 0, 0, 1, 'b100, 0, 0, 0, 0);
    add(1, 'b001, 'b001, 0, 0, 0, 1, 'b000, 0, 0, 0, 0);
    add(1, 'b001, 'b001, 1, 0, 0, 1, 'b001, 'b001, 0, 1, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b001, 0, 0, 0, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b000, 0, 0, 0, 0);
    // Watchdog: master 1 stalls forever, master 2 waiting behind it.
    add(1, 'b110, 'b110, 0, 0, 'h8000, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < TO; s++)
      add(1, 'b110, 'b110, 0, 0, 'h8000, 1, 'b010, 0, 0, 1, 0);
    add(1, 'b110, 'b110, 0, 0, 'h8000, 1, 'b010, 0, 'b010, 0, 1);
    add(1, 'b110, 'b110, 0, 0, 'h8000, 1, 'b000, 0, 0, 0, 0);
    add(1, 'b110, 'b110, 1, 0, 'h8000, 1, 'b100, 'b100, 0, 1, 0);
    add(1, 'b010, 'b010, 0, 0, 'h8000, 1, 'b100, 0, 0, 0, 0);
    add(1, 'b010, 'b010, 0, 0, 'h8000, 1, 'b000, 0, 0, 0, 0);
    // Ack landing exactly on the expiry cycle, twice in a row.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < TO - 1; s++)
        add(1, 'b010, 'b010, 0, 0, 'hC000, 1, 'b010, 0, 0, 1, 0);
      add(1, 'b010, 'b010, 1, 0, 'hC000, 1, 'b010, 'b010, 0, 1, 0);
    end
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b010, 0, 0, 0, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b000, 0, 0, 0, 0);
    // Reset mid-transfer, then arbitration restarts at master 0.
    add(1, 'b100, 'b100, 0, 0, 'hE000, 1, 0, 0, 0, 0, 0);
    add(1, 'b100, 'b100, 0, 0, 'hE000, 1, 'b100, 0, 0, 1, 0);
    add(0, 'b100, 'b100, 1, 0, 'hE000, 1, 0, 0, 0, 0, 0);
    add(1, 'b111, 'b111, 0, 0, 'hE000, 1, 0, 0, 0, 0, 0);
    add(1, 'b111, 'b111, 0, 1, 'hE000, 1, 'b001, 0, 'b001, 1, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b001, 0, 0, 0, 0);
    add(1, 'b000, 'b000, 0, 0, 0, 1, 'b000, 0, 0, 0, 0);

    rstn_i = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_dat_i[i*DW +: DW] = 32'hA5A5_0000 + 32'(i);
      m_sel_i[i*SW +: SW] = SW'(1 << i);
    end
    repeat (2) @(posedge clk);

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1;
      cur = vq[k];
      vidx = k;
      cur_vld = 1'b1;
      m_cyc_i = vq[k].cyc;
      m_stb_i = vq[k].stb;
      m_we_i  = vq[k].stb & 3'b101;
      m_adr_i = {N{vq[k].adr}};
      s_ack_i = vq[k].ack;
      s_err_i = vq[k].err;
      s_dat_i = 32'h5A00_0000 + 32'(k);
      if (vq[k].rstn) begin
        rstn_i = 1'b1;
      end else begin
        #1;
        rstn_i = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cur_vld = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
